// File: rtl/mips_cpu_divider_sd_pkg.sv
// Shared types and helpers for the multi-cycle restoring divider.
package mips_cpu_div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} div_state_t;

  localparam int ABS_W = 64;
  localparam logic [ABS_W-1:0] RES_ZERO = '0;
  localparam logic DBZ_SET = 1'b1;
  localparam logic DBZ_CLR = 1'b0;

  // Magnitude of a sign-extended two's-complement value.
  function automatic logic [ABS_W-1:0] abs_val(input logic [ABS_W-1:0] v);
    return v[ABS_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mips_cpu_divider_sd_if.sv
// Request/result bundle between the execute stage and the divider.
interface mips_cpu_divider_sd_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_signed;
  logic             abort;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             busy;
  logic             done;
  logic             dbz;

  modport master (output start, is_signed, abort, Dividend, Divisor,
                  input  Quotient, Remainder, busy, done, dbz);
  modport slave  (input  start, is_signed, abort, Dividend, Divisor,
                  output Quotient, Remainder, busy, done, dbz);
endinterface

// File: rtl/mips_cpu_divider_sd_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module mips_cpu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] dvs_ext;
  logic           ge;
  logic           unused_acc_msb;

  // Incoming acc is always below divisor, so its top bit is zero here.
  assign unused_acc_msb = acc[WIDTH];
  assign shifted        = {acc[WIDTH-1:0], q[WIDTH-1]};
  assign dvs_ext        = {1'b0, divisor};
  assign ge             = (shifted >= dvs_ext);

  always_comb begin
    acc_next = ge ? (shifted - dvs_ext) : shifted;
    q_next   = {q[WIDTH-2:0], ge};
  end
endmodule

// File: rtl/mips_cpu_divider_sd.sv
// Signed/unsigned multi-cycle restoring divider feeding HI/LO.
module mips_cpu_divider_sd
  import mips_cpu_div_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_cpu_divider_sd_if.slave  bus
);
  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d, acc_step;
  logic [WIDTH-1:0] q_q, q_d, q_step;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             done_q, done_d, dbz_q, dbz_d;

  logic [ABS_W-1:0] dvd_abs, dvs_abs;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, acc_lo;
  logic             dvd_neg, dvs_neg;
  logic             unused_hi;

  assign dvd_neg = bus.is_signed & bus.Dividend[WIDTH-1];
  assign dvs_neg = bus.is_signed & bus.Divisor[WIDTH-1];
  assign dvd_abs = abs_val(ABS_W'(signed'(bus.Dividend)));
  assign dvs_abs = abs_val(ABS_W'(signed'(bus.Divisor)));
  assign dvd_mag = dvd_neg ? dvd_abs[WIDTH-1:0] : bus.Dividend;
  assign dvs_mag = dvs_neg ? dvs_abs[WIDTH-1:0] : bus.Divisor;
  assign acc_lo  = acc_q[WIDTH-1:0];
  assign unused_hi = ^{dvd_abs[ABS_W-1:WIDTH], dvs_abs[ABS_W-1:WIDTH], acc_q[WIDTH]};

  mips_cpu_div_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .q        (q_q),
    .divisor  (dvs_q),
    .acc_next (acc_step),
    .q_next   (q_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.abort) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end else if (bus.start) begin
          if (bus.Divisor == '0 || bus.Dividend == '0) begin
            // Shortcut results skip the iteration entirely.
            state_d = DONE;
            quo_d   = RES_ZERO[WIDTH-1:0];
            rem_d   = RES_ZERO[WIDTH-1:0];
            dbz_d   = (bus.Divisor == '0) ? DBZ_SET : DBZ_CLR;
            done_d  = 1'b1;
          end else begin
            state_d = CALC;
            acc_d   = '0;
            q_d     = dvd_mag;
            dvs_d   = dvs_mag;
            qneg_d  = dvd_neg ^ dvs_neg;
            rneg_d  = dvd_neg;
            cnt_d   = '0;
            done_d  = 1'b0;
            dbz_d   = DBZ_CLR;
          end
        end
      end
      CALC: begin
        if (bus.abort) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end else begin
          acc_d = acc_step;
          q_d   = q_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = SIGN;
        end
      end
      SIGN: begin
        if (bus.abort) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end else begin
          quo_d   = qneg_q ? -q_q : q_q;
          rem_d   = rneg_q ? -acc_lo : acc_lo;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.Quotient  = quo_q;
  assign bus.Remainder = rem_q;
  assign bus.busy      = (state_q == CALC) || (state_q == SIGN);
  assign bus.done      = done_q;
  assign bus.dbz       = dbz_q;
endmodule

// File: tb/tb_mips_cpu_divider_sd.sv
// Directed and random checks of the divider at WIDTH=32 and WIDTH=8.
module tb_mips_cpu_divider_sd;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_cpu_divider_sd_if #(.WIDTH(32)) bus32();
  mips_cpu_divider_sd_if #(.WIDTH(8))  bus8();

  mips_cpu_divider_sd #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
  mips_cpu_divider_sd #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference built on the simulator's own signed division (truncating toward zero).
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input bit sgn, input int w);
    exp_t e;
    longint sa, sd, qq, rr;
    logic [63:0] m, qu, ru;
    m  = (64'd1 << w) - 64'd1;
    sa = longint'(a);
    sd = longint'(b);
    if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && b[w-1]) sd = sd - (longint'(1) << w);
    if (b == 0) begin
      e.q = 0; e.r = 0; e.dbz = 1'b1; e.lat = 1;
    end else if (a == 0) begin
      e.q = 0; e.r = 0; e.dbz = 1'b0; e.lat = 1;
    end else begin
      qq = sa / sd;
      rr = sa % sd;
      qu = qq;
      ru = rr;
      e.q = qu[31:0] & m[31:0];
      e.r = ru[31:0] & m[31:0];
      e.dbz = 1'b0;
      e.lat = w + 2;
    end
    return e;
  endfunction

  task automatic set_in(input int w, input logic st, input logic sg, input logic ab,
                        input logic [31:0] a, input logic [31:0] b);
    if (w == 32) begin
      bus32.start = st; bus32.is_signed = sg; bus32.abort = ab;
      bus32.Dividend = a; bus32.Divisor = b;
    end else begin
      bus8.start = st; bus8.is_signed = sg; bus8.abort = ab;
      bus8.Dividend = a[7:0]; bus8.Divisor = b[7:0];
    end
  endtask

  task automatic sample(input int w, output logic d, output logic bz, output logic dz,
                        output logic [31:0] q, output logic [31:0] r);
    if (w == 32) begin
      d = bus32.done; bz = bus32.busy; dz = bus32.dbz;
      q = bus32.Quotient; r = bus32.Remainder;
    end else begin
      d = bus8.done; bz = bus8.busy; dz = bus8.dbz;
      q = {24'd0, bus8.Quotient}; r = {24'd0, bus8.Remainder};
    end
  endtask

  // Issue one division; optionally pulse start again (poke_at edges later) while busy.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                        input bit sgn, input string tag, input int poke_at = -1);
    exp_t e;
    int n, bcnt;
    logic d, bz, dz;
    logic [31:0] q, r;
    logic [63:0] m, prod;
    @(negedge clk);
    set_in(w, 1'b1, sgn, 1'b0, a, b);
    sb.push_back(model(a, b, sgn, w));
    n = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      n++;
      sample(w, d, bz, dz, q, r);
      if (bz) bcnt++;
      if (n == poke_at) set_in(w, 1'b1, 1'b0, 1'b0, 32'd50, 32'd5);
      else              set_in(w, 1'b0, sgn, 1'b0, a, b);
    end while (!d && n < 200);
    e = sb.pop_front();
    check({tag, "_done"}, d, 1'b1);
    check({tag, "_q"}, q, e.q);
    check({tag, "_r"}, r, e.r);
    check({tag, "_dbz"}, dz, e.dbz);
    check({tag, "_lat"}, n, e.lat);
    check({tag, "_busy"}, bcnt, (e.lat == 1) ? 0 : w + 1);
    if (b != 0) begin
      m = (64'd1 << w) - 64'd1;
      prod = ({32'd0, q} * {32'd0, b} + {32'd0, r}) & m;
      check({tag, "_ident"}, prod, {32'd0, a});
      if (sgn && r != 0) check({tag, "_rsign"}, r[w-1], a[w-1]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    bit sg;
    reset = 1'b0;
    set_in(32, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_in(8, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #12;
    check("rst_q", bus32.Quotient, 32'd0);
    check("rst_r", bus32.Remainder, 32'd0);
    check("rst_busy", bus32.busy, 1'b0);
    check("rst_done", bus32.done, 1'b0);
    check("rst_dbz", bus32.dbz, 1'b0);
    check("rst_q8", bus8.Quotient, 8'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(32, 32'd100, 32'd7, 1'b0, "u100_7");
    check("u100_7_const", bus32.Quotient, 32'd14);
    run_op(32, 32'hFFFFFFF9, 32'd2, 1'b1, "s_m7_2");
    check("s_m7_2_qc", bus32.Quotient, 32'hFFFFFFFD);
    check("s_m7_2_rc", bus32.Remainder, 32'hFFFFFFFF);
    run_op(32, 32'hFFFFFFF9, 32'd2, 1'b0, "u_m7_2");
    check("u_m7_2_qc", bus32.Quotient, 32'h7FFFFFFC);
    run_op(32, 32'd55, 32'd0, 1'b0, "dbz55");
    check("dbz55_flag", bus32.dbz, 1'b1);
    run_op(32, 32'd9, 32'd3, 1'b0, "u9_3");
    check("u9_3_dbz", bus32.dbz, 1'b0);
    run_op(32, 32'd0, 32'd5, 1'b1, "zero_dvd");
    run_op(32, 32'h80000000, 32'hFFFFFFFF, 1'b1, "min_m1");
    check("min_m1_qc", bus32.Quotient, 32'h80000000);
    run_op(32, 32'd100, 32'hFFFFFFF9, 1'b1, "s100_m7");
    run_op(32, 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, "sm100_m7");
    run_op(32, 32'hFFFFFFFF, 32'd1, 1'b0, "umax_1");

    // Abort at cycle 10 of a 1000/3 run leaves the previous result visible.
    @(negedge clk);
    set_in(32, 1'b1, 1'b0, 1'b0, 32'd1000, 32'd3);
    @(negedge clk);
    set_in(32, 1'b0, 1'b0, 1'b0, 32'd1000, 32'd3);
    repeat (8) @(negedge clk);
    bus32.abort = 1'b1;
    @(negedge clk);
    bus32.abort = 1'b0;
    check("abort_busy", bus32.busy, 1'b0);
    check("abort_done", bus32.done, 1'b0);
    check("abort_q", bus32.Quotient, 32'hFFFFFFFF);
    check("abort_r", bus32.Remainder, 32'd0);
    repeat (5) @(negedge clk);
    check("abort_done_late", bus32.done, 1'b0);

    // Abort beats start on the same edge.
    run_op(32, 32'd20, 32'd6, 1'b0, "u20_6");
    @(negedge clk);
    set_in(32, 1'b1, 1'b0, 1'b1, 32'd50, 32'd5);
    @(negedge clk);
    set_in(32, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("prio_busy", bus32.busy, 1'b0);
    check("prio_done", bus32.done, 1'b0);
    check("prio_q", bus32.Quotient, 32'd3);

    run_op(32, 32'd1000, 32'd3, 1'b0, "ignore_start", 14);

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    set_in(32, 1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    @(negedge clk);
    set_in(32, 1'b0, 1'b0, 1'b0, 32'd100, 32'd7);
    repeat (18) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_q", bus32.Quotient, 32'd0);
    check("mid_rst_r", bus32.Remainder, 32'd0);
    check("mid_rst_busy", bus32.busy, 1'b0);
    check("mid_rst_done", bus32.done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    run_op(32, 32'd77, 32'd8, 1'b1, "post_rst");

    for (int i = 0; i < 250; i++) begin
      a  = (i % 50 == 0) ? 32'd0 : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFF) : $urandom;
      sg = 1'($urandom_range(0, 1));
      run_op(32, a, b, sg, "rnd32");
    end

    run_op(8, 32'h80, 32'hFF, 1'b1, "w8_min_m1");
    run_op(8, 32'hF9, 32'h02, 1'b1, "w8_m7_2");
    run_op(8, 32'h37, 32'h00, 1'b0, "w8_dbz");
    for (int i = 0; i < 300; i++) begin
      a  = $urandom & 32'hFF;
      b  = $urandom & 32'hFF;
      sg = 1'($urandom_range(0, 1));
      run_op(8, a, b, sg, "rnd8");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
